// File: rtl/lfsr_word_packer.sv
// -----------------------------------------------------------------------------
// lfsr_word_packer
//
// Packs a serial bit stream from an upstream LFSR into WORD_WIDTH-bit words
// and queues them in a small FIFO for a ready/valid consumer. The first bit
// of a word ends up in the MSB. Words that complete while the FIFO has no
// free slot are dropped and counted in a saturating 8-bit counter.
//
// Optional feature: define LFSR_PACKER_HEALTH_CHECK_EN to compile in a
// repetition-count test that raises a sticky health_fail once 32 consecutive
// identical bits have been accepted. Without it health_fail is tied low.
//
// Ports:
//   clock          rising-edge clock of all state
//   reset          asynchronous, active-high reset
//   bit_in         serial data bit
//   bit_valid      qualifies bit_in (low while the upstream loads a seed)
//   flush          synchronous clear of partial word, FIFO and health state
//   word_out       FIFO head word (0 when the FIFO is empty)
//   word_valid     FIFO non-empty
//   word_ready     consumer accept; pop on word_valid & word_ready
//   fifo_level     number of queued words
//   overflow_count saturating count of dropped words
//   health_fail    sticky stuck-stream flag
// -----------------------------------------------------------------------------
module lfsr_word_packer #(
    parameter int WORD_WIDTH = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          bit_in,
    input  logic                          bit_valid,
    input  logic                          flush,
    output logic [WORD_WIDTH-1:0]         word_out,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    overflow_count,
    output logic                          health_fail
);

    localparam int CW = $clog2(WORD_WIDTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;

    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [7:0]            ovf_q, ovf_d;
    logic [WORD_WIDTH-1:0] mem [FIFO_DEPTH];

    logic                  accept;
    logic                  complete;
    logic                  pop;
    logic                  slot_free;
    logic                  push;
    logic                  drop;
    logic [WORD_WIDTH-1:0] full_word;

    // Handshake decode. A flush edge discards the bit, push and pop.
    always_comb begin
        accept    = bit_valid && !flush;
        complete  = accept && (bit_cnt_q == CW'(WORD_WIDTH - 1));
        full_word = {shift_q[WORD_WIDTH-2:0], bit_in};
        pop       = (level_q != '0) && word_ready && !flush;
        // A full FIFO still has room when its head leaves on the same edge.
        slot_free = (level_q < LW'(FIFO_DEPTH)) || pop;
        push      = complete && slot_free;
        drop      = complete && !slot_free;
    end

    // NOTE: every next-state variable gets its hold value first, so no path
    // through this block can leave one unassigned and infer a latch.
    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        level_d   = level_q;
        ovf_d     = ovf_q;

        if (flush) begin
            shift_d   = '0;
            bit_cnt_d = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
        end else begin
            if (accept) begin
                shift_d   = full_word;
                bit_cnt_d = complete ? '0 : bit_cnt_q + CW'(1);
            end
            if (push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            level_d = level_q + LW'(push) - LW'(pop);
        end

        if (drop && (ovf_q != 8'hFF)) ovf_d = ovf_q + 8'd1;
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples its next value from the same pre-edge snapshot.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_q   <= '0;
            bit_cnt_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            ovf_q     <= '0;
        end else begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            ovf_q     <= ovf_d;
        end
    end

    // NOTE: the storage array has no reset; a slot is only ever read after it
    // was written, and the empty case forces word_out to zero below.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= full_word;
    end

    assign word_valid     = (level_q != '0);
    assign word_out       = word_valid ? mem[rd_ptr_q] : '0;
    assign fifo_level     = level_q;
    assign overflow_count = ovf_q;

`ifdef LFSR_PACKER_HEALTH_CHECK_EN
    // Repetition-count test. run_q == 0 means no bit accepted since reset or
    // flush, so the next accepted bit always starts a run of one.
    logic [5:0] run_q, run_d;
    logic       last_q, last_d;
    logic       health_q, health_d;

    always_comb begin
        run_d    = run_q;
        last_d   = last_q;
        health_d = health_q;
        if (flush) begin
            run_d    = '0;
            health_d = 1'b0;
        end else if (accept) begin
            last_d = bit_in;
            if ((run_q == '0) || (bit_in != last_q)) begin
                run_d = 6'd1;
            end else if (run_q != 6'd32) begin
                run_d = run_q + 6'd1;
            end
            if (run_d == 6'd32) health_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            run_q    <= '0;
            last_q   <= 1'b0;
            health_q <= 1'b0;
        end else begin
            run_q    <= run_d;
            last_q   <= last_d;
            health_q <= health_d;
        end
    end

    assign health_fail = health_q;
`else
    assign health_fail = 1'b0;
`endif

endmodule

// File: tb/tb_lfsr_word_packer.sv
// -----------------------------------------------------------------------------
// tb_lfsr_word_packer
//
// Drives directed scenarios followed by randomized traffic into
// lfsr_word_packer (default parameters) and compares every output, every
// cycle, against a queue-based reference model. Inputs change on the falling
// edge; outputs are compared on the falling edge before the next rising edge.
// Health expectations follow LFSR_PACKER_HEALTH_CHECK_EN as compiled.
// -----------------------------------------------------------------------------
module tb_lfsr_word_packer;

    localparam int W = 8;
    localparam int D = 4;
`ifdef LFSR_PACKER_HEALTH_CHECK_EN
    localparam bit HEALTH_EN = 1'b1;
`else
    localparam bit HEALTH_EN = 1'b0;
`endif

    logic         clock = 1'b0;
    logic         reset;
    logic         bit_in;
    logic         bit_valid;
    logic         flush;
    logic [W-1:0] word_out;
    logic         word_valid;
    logic         word_ready;
    logic [2:0]   fifo_level;
    logic [7:0]   overflow_count;
    logic         health_fail;

    lfsr_word_packer #(.WORD_WIDTH(W), .FIFO_DEPTH(D)) dut (
        .clock          (clock),
        .reset          (reset),
        .bit_in         (bit_in),
        .bit_valid      (bit_valid),
        .flush          (flush),
        .word_out       (word_out),
        .word_valid     (word_valid),
        .word_ready     (word_ready),
        .fifo_level     (fifo_level),
        .overflow_count (overflow_count),
        .health_fail    (health_fail)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int unsigned m_partial;
    int          m_cnt;
    int unsigned m_fifo[$];
    int          m_ovf;
    int          m_run;
    bit          m_last;
    bit          m_health;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    endtask

    function automatic void model_reset();
        m_partial = 0;
        m_cnt     = 0;
        m_fifo.delete();
        m_ovf     = 0;
        m_run     = 0;
        m_last    = 1'b0;
        m_health  = 1'b0;
    endfunction

    // Effect of one rising edge on the model.
    function automatic void model_edge(input bit bv, input bit b, input bit rdy, input bit fl);
        bit done;
        if (fl) begin
            m_partial = 0;
            m_cnt     = 0;
            m_fifo.delete();
            m_run     = 0;
            m_health  = 1'b0;
            return;
        end
        done = 1'b0;
        if (bv) begin
            m_partial = ((m_partial * 2) + b) % (1 << W);
            m_cnt++;
            if (m_cnt == W) begin
                m_cnt = 0;
                done  = 1'b1;
            end
            if (m_run == 0 || b != m_last) m_run = 1;
            else m_run++;
            m_last = b;
            if (HEALTH_EN && m_run >= 32) m_health = 1'b1;
        end
        if (rdy && m_fifo.size() > 0) void'(m_fifo.pop_front());
        if (done) begin
            if (m_fifo.size() < D) m_fifo.push_back(m_partial);
            else if (m_ovf < 255) m_ovf++;
        end
    endfunction

    task automatic check_outputs(input string tag);
        int unsigned head;
        head = (m_fifo.size() > 0) ? m_fifo[0] : 0;
        check({tag, "_valid"},  word_valid,     (m_fifo.size() > 0));
        check({tag, "_word"},   word_out,       head);
        check({tag, "_level"},  fifo_level,     m_fifo.size());
        check({tag, "_ovf"},    overflow_count, m_ovf);
        check({tag, "_health"}, health_fail,    m_health);
    endtask

    // One clock cycle: apply inputs, compare current outputs, take the edge.
    task automatic step(input string tag, input bit bv, input bit b, input bit rdy, input bit fl);
        bit_valid  = bv;
        bit_in     = b;
        word_ready = rdy;
        flush      = fl;
        check_outputs(tag);
        @(posedge clock);
        model_edge(bv, b, rdy, fl);
        @(negedge clock);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        #1;
        check("rst_valid",  word_valid,     1'b0);
        check("rst_word",   word_out,       '0);
        check("rst_level",  fifo_level,     '0);
        check("rst_ovf",    overflow_count, '0);
        check("rst_health", health_fail,    1'b0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < D + 2; i++) step("drain", 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [7:0] pattern;
        bit         rdy;
        bit         bias_on;
        bit         bias_bit;

        reset      = 1'b1;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        flush      = 1'b0;
        word_ready = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        apply_reset();

        // Serial pattern 1,0,1,1,0,0,1,0 packs to 0xB2.
        pattern = 8'hB2;
        for (int i = 7; i >= 0; i--) step("pat", 1'b1, pattern[i], 1'b1, 1'b0);
        check("pat_b2_word",  word_out,   8'hB2);
        check("pat_b2_valid", word_valid, 1'b1);
        step("pat_hold", 1'b0, 1'b0, 1'b1, 1'b0);
        check("pat_b2_gone", word_valid, 1'b0);

        // Consumer stalled: 5 words complete, 4 kept, 1 dropped.
        for (int i = 0; i < 40; i++) step("stall", 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        check("stall_level", fifo_level,     3'd4);
        check("stall_ovf",   overflow_count, 8'd1);

        // Completion coinciding with a pop from a full FIFO.
        for (int i = 0; i < 7; i++) step("fullpop", 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        step("fullpop", 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        check("fullpop_level", fifo_level,     3'd4);
        check("fullpop_ovf",   overflow_count, 8'd1);
        drain();

        // bit_valid gap in the middle of a word.
        pattern = 8'($urandom);
        for (int i = 7; i >= 5; i--) step("gap", 1'b1, pattern[i], 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)  step("gap_idle", 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        for (int i = 4; i >= 0; i--) step("gap", 1'b1, pattern[i], 1'b0, 1'b0);
        check("gap_word", word_out, pattern);
        drain();

        // Flush with two words queued and a partial word in progress.
        for (int i = 0; i < 19; i++) step("flq", 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        check("flq_level_pre", fifo_level, 3'd2);
        step("flq_flush", 1'b1, 1'b1, 1'b1, 1'b1);
        check("flq_level", fifo_level, 3'd0);
        check("flq_valid", word_valid, 1'b0);
        pattern = 8'($urandom);
        for (int i = 7; i >= 0; i--) step("flq_fresh", 1'b1, pattern[i], 1'b0, 1'b0);
        check("flq_fresh_word", word_out, pattern);
        drain();

        // Randomized traffic with bursts of constant bits, flushes and a reset.
        rdy      = 1'b1;
        bias_on  = 1'b0;
        bias_bit = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) begin
                bias_on  = ($urandom_range(0, 2) == 0);
                bias_bit = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 7) == 0) rdy = ~rdy;
            if (c == 750) apply_reset();
            step("rand",
                 ($urandom_range(0, 3) != 0),
                 bias_on ? bias_bit : 1'($urandom_range(0, 1)),
                 rdy,
                 ($urandom_range(0, 149) == 0));
        end

        // Repetition-count boundaries: 32 zeros trip, 31 zeros then a one do not.
        step("hc_flush", 1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 32; i++) step("hc32", 1'b1, 1'b0, 1'b1, 1'b0);
        check("hc32_fail", health_fail, HEALTH_EN);
        step("hc_flush2", 1'b0, 1'b0, 1'b1, 1'b1);
        check("hc_cleared", health_fail, 1'b0);
        for (int i = 0; i < 31; i++) step("hc31", 1'b1, 1'b0, 1'b1, 1'b0);
        step("hc31_one", 1'b1, 1'b1, 1'b1, 1'b0);
        check("hc31_fail", health_fail, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lfsr_word_packer.md
LFSR_WORD_PACKER -- requirements
Module: lfsr_word_packer

Interface
REQ-001 The block SHALL have parameter WORD_WIDTH, default 8, giving bits per packed word (legal range 2..32).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, giving the number of output word slots (power of two, 2..16).
REQ-003 The block SHALL have input clock, 1 bit, the rising-edge clock of all state.
REQ-004 The block SHALL have input reset, 1 bit, asynchronous, active-high.
REQ-005 The block SHALL have input bit_in, 1 bit, the serial bit from the upstream LFSR feedback output.
REQ-006 The block SHALL have input bit_valid, 1 bit, qualifying bit_in; upstream drives it low while loading a seed.
REQ-007 The block SHALL have input flush, 1 bit, a synchronous clear of the partial word and the FIFO.
REQ-008 The block SHALL have output word_out, WORD_WIDTH bits, the FIFO head word.
REQ-009 The block SHALL have output word_valid, 1 bit, high when the FIFO is non-empty.
REQ-010 The block SHALL have input word_ready, 1 bit, consumer acceptance; a pop occurs when word_valid and word_ready are both high at a rising edge.
REQ-011 The block SHALL have output fifo_level, clog2(FIFO_DEPTH)+1 bits, the current word count.
REQ-012 The block SHALL have output overflow_count, 8 bits, the saturating count of dropped words.
REQ-013 The block SHALL have output health_fail, 1 bit, a sticky stuck-stream flag.

Function
REQ-014 On each edge with bit_valid=1, bit_in SHALL shift into the LSB of the shift register and prior bits shift left; the first bit of a word therefore ends in the MSB.
REQ-015 A bit counter SHALL count accepted bits 0..WORD_WIDTH-1 and wrap to 0 on the edge that accepts bit WORD_WIDTH-1 (word completion).
REQ-016 On completion, the full word (including the bit accepted that edge) SHALL be written to the FIFO tail on the same edge if a slot is free.
REQ-017 A slot SHALL be free if fifo_level<FIFO_DEPTH, or if fifo_level=FIFO_DEPTH and a pop occurs on the same edge.
REQ-018 If no slot is free on completion, the word SHALL be dropped, FIFO contents are unchanged, and overflow_count increments, saturating at 255.
REQ-019 A completed word SHALL appear on word_out with word_valid=1 in the first cycle after its completion edge when the FIFO was empty (latency 1 cycle).
REQ-020 word_out and word_valid SHALL be stable while word_valid=1 and word_ready=0.
REQ-021 A simultaneous push and pop SHALL leave fifo_level unchanged, and the FIFO SHALL preserve strict arrival order.
REQ-022 When bit_valid=0, the shift register and bit counter SHALL hold, and the FIFO still pops normally.
REQ-023 word_out SHALL be 0 when word_valid=0.
REQ-024 flush=1 at an edge SHALL clear the bit counter, shift register, FIFO pointers and health state, and SHALL discard that edge's bit, push and pop; overflow_count is unaffected.

Reset
REQ-025 Reset SHALL asynchronously force word_valid=0, word_out=0, fifo_level=0, overflow_count=0 and health_fail=0, and clear the bit counter, shift register, FIFO pointers and run counter.
REQ-026 The first bit accepted after reset deasserts SHALL be bit 0 of a new word; a partial word in progress at reset SHALL be lost.

Configuration
REQ-027 Macro LFSR_PACKER_HEALTH_CHECK_EN SHALL compile in a repetition-count test: a 6-bit run counter tracks consecutive identical accepted bits (the first accepted bit sets the run to 1).
REQ-028 With the macro defined, health_fail SHALL set on the edge where the run reaches 32 and stay set until reset or flush; packing continues unaffected.
REQ-029 Without the macro, the run counter SHALL be absent, health_fail is tied to 0, and the port list is unchanged.

Verification
REQ-030 Reset, then bits 1,0,1,1,0,0,1,0 with bit_valid=1 and word_ready=1 -> word_out=0xB2 and word_valid=1 for exactly one cycle, starting the cycle after the 8th bit.
REQ-031 word_ready=0 with 40 continuous random bits -> 4 words held in order; fifo_level=4; 5th word dropped; overflow_count=1.
REQ-032 FIFO full (level 4), word completion on the same edge as a pop -> fifo_level stays 4, overflow_count unchanged, new word at the tail.
REQ-033 bit_valid low for 5 cycles in the middle of a word -> the packed word equals the same bits sent without the gap.
REQ-034 flush after 3 bits with 2 words queued -> fifo_level=0, word_valid=0, and the next 8 bits form a fresh word.
REQ-035 With LFSR_PACKER_HEALTH_CHECK_EN, 32 consecutive 0 bits -> health_fail=1 after the 32nd bit, cleared by flush; with 31 zeros then a 1 -> health_fail stays 0.
